// File: rtl/onehot_encoder_pipe.sv
// rtl/onehot_encoder_pipe.sv - registered one-hot to binary encoder with backpressure and error counter
// Optional build macro: ENC_PRIORITY_EN (multi-hot codes resolve to the lowest set index instead of erroring)
module onehot_encoder_pipe #(
    parameter int N  = 8,
    parameter int CW = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_code,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_idx,
    output logic          out_err,
    output logic [CW-1:0] err_cnt,
    input  logic          cnt_clr
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_deliver;
    logic            w_zero;
    logic            w_multi;
    logic [IW-1:0]   w_low_idx;
    logic [IW-1:0]   w_idx;
    logic            w_err;
    logic [IW-1:0]   r_idx;
    logic            r_err;
    logic [CW-1:0]   r_cnt;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [N-1:0]  ONE_N   = {{(N-1){1'b0}}, 1'b1};

    // Output register occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake decode and next occupancy; a full register only frees up when the consumer takes it
    always_comb begin
        in_ready    = 1'b1;
        w_state_nxt = r_state;
        out_valid   = 1'b0;
        case (r_state)
            S_EMPTY: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
            S_FULL: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
        endcase
        w_accept  = in_valid && in_ready;
        w_deliver = out_valid && out_ready;
        if (w_accept) begin
            w_state_nxt = S_FULL;
        end else if (w_deliver) begin
            w_state_nxt = S_EMPTY;
        end
    end

    // Lowest set bit index: scanning downward lets the lowest hit win
    always_comb begin
        w_low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_code[i]) begin
                w_low_idx = IW'(i);
            end
        end
    end

    assign w_zero  = (in_code == '0);
    // Clearing the lowest set bit leaves something behind only for multi-hot codes
    assign w_multi = |(in_code & (in_code - ONE_N));

    // Code classification; all-zero is an error in every build
    always_comb begin
        w_idx = w_low_idx;
        w_err = 1'b0;
        if (w_zero) begin
            w_idx = '0;
            w_err = 1'b1;
        end
`ifdef ENC_PRIORITY_EN
        else if (w_multi) begin
            w_idx = w_low_idx;
            w_err = 1'b0;
        end
`else
        else if (w_multi) begin
            w_idx = '0;
            w_err = 1'b1;
        end
`endif
    end

    // Result register: loads only on accept, otherwise holds through backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_idx <= w_idx;
            r_err <= w_err;
        end
    end

    // Saturating error counter; clear beats a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_accept && w_err && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_idx = r_idx;
    assign out_err = r_err;
    assign err_cnt = r_cnt;

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// tb/tb_onehot_encoder_pipe.sv - directed vector bench for onehot_encoder_pipe
module tb_onehot_encoder_pipe;

    localparam int N  = 8;
    localparam int CW = 4;
    localparam int IW = $clog2(N);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_code;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_idx;
    logic          out_err;
    logic [CW-1:0] err_cnt;
    logic          cnt_clr;

    int n_tests;
    int n_fail;
    int m_cnt;

    typedef struct {
        logic [N-1:0] code;
        int           idx;
        int           err;
    } vec_t;

    vec_t vecs[10];

    onehot_encoder_pipe #(.N(N), .CW(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_code  (in_code),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx  (out_idx),
        .out_err  (out_err),
        .err_cnt  (err_cnt),
        .cnt_clr  (cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_err(input int e);
        if (e != 0 && m_cnt < (1 << CW) - 1) m_cnt++;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        m_cnt     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;

        for (int i = 0; i < 8; i++) begin
            vecs[i].code = 8'h01 << i;
            vecs[i].idx  = i;
            vecs[i].err  = 0;
        end
        vecs[8].code = 8'h00; vecs[8].idx = 0; vecs[8].err = 1;
`ifdef ENC_PRIORITY_EN
        vecs[9].code = 8'h28; vecs[9].idx = 3; vecs[9].err = 0;
`else
        vecs[9].code = 8'h28; vecs[9].idx = 0; vecs[9].err = 1;
`endif

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 1);

        // back-to-back table walk with out_ready=1
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_code  = vecs[i].code;
            #1;
            chk($sformatf("vec%0d_in_ready", i), int'(in_ready), 1);
            model_err(vecs[i].err);
            @(negedge clk);
            chk($sformatf("vec%0d_out_valid", i), int'(out_valid), 1);
            chk($sformatf("vec%0d_out_idx", i), int'(out_idx), vecs[i].idx);
            chk($sformatf("vec%0d_out_err", i), int'(out_err), vecs[i].err);
            chk($sformatf("vec%0d_err_cnt", i), int'(err_cnt), m_cnt);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_out_valid", int'(out_valid), 0);
        chk("idle_err_cnt", int'(err_cnt), m_cnt);

        // idle input must not change state even with garbage code
        in_code = 8'h00;
        @(negedge clk);
        chk("idle_garbage_cnt", int'(err_cnt), m_cnt);
        chk("idle_garbage_valid", int'(out_valid), 0);

        // backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 8'h10;
        @(negedge clk);
        chk("bp_valid", int'(out_valid), 1);
        chk("bp_idx", int'(out_idx), 4);
        in_code = 8'h04;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk($sformatf("bp_stall%0d_in_ready", s), int'(in_ready), 0);
            @(negedge clk);
            chk($sformatf("bp_stall%0d_idx", s), int'(out_idx), 4);
            chk($sformatf("bp_stall%0d_valid", s), int'(out_valid), 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", int'(in_ready), 1);
        @(negedge clk);
        chk("bp_next_idx", int'(out_idx), 2);
        chk("bp_next_valid", int'(out_valid), 1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drain_valid", int'(out_valid), 0);

        // saturation: 20 all-zero accepts
        in_valid = 1'b1;
        in_code  = 8'h00;
        for (int k = 0; k < 20; k++) begin
            model_err(1);
            @(negedge clk);
        end
        chk("sat_model_is_max", m_cnt, 15);
        chk("sat_err_cnt", int'(err_cnt), 15);
        chk("sat_out_err", int'(out_err), 1);

        // clear beats increment
        cnt_clr = 1'b1;
        @(negedge clk);
        m_cnt = 0;
        cnt_clr = 1'b0;
        chk("clr_err_cnt", int'(err_cnt), 0);
        in_valid = 1'b1;
        in_code  = 8'h00;
        @(negedge clk);
        chk("after_clr_inc", int'(err_cnt), 1);

        // async reset while FULL and stalled
        out_ready = 1'b0;
        in_code   = 8'h00;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_arst_valid", int'(out_valid), 1);
        chk("pre_arst_err", int'(out_err), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_idx", int'(out_idx), 0);
        chk("arst_err", int'(out_err), 0);
        chk("arst_cnt", int'(err_cnt), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = 8'h80;
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_arst_valid", int'(out_valid), 1);
        chk("post_arst_idx", int'(out_idx), 7);
        chk("post_arst_err", int'(out_err), 0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
